// File: rtl/pipe_field_gen.sv
// Scrolling pipe-column field: NUM_COLS columns move left by `speed` per tick in RUN
// and respawn on the right with an LFSR-derived gap centre; counts wraps as a score.
module pipe_col #(
  parameter int COORD_W = 11,
  parameter int SPEED_W = 3,
  parameter int INIT_X  = 0,
  parameter int INIT_Y  = 0,
  parameter int PERIOD  = 720
) (
  input  logic               gameClk,
  input  logic               reset,
  input  logic               i_move,
  input  logic               i_load,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [COORD_W-1:0] i_new_y,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_wrap
);
  localparam logic [COORD_W-1:0] X0  = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] Y0  = COORD_W'(INIT_Y);
  localparam logic [COORD_W-1:0] PER = COORD_W'(PERIOD);

  logic [COORD_W-1:0] r_x, r_y;
  logic [COORD_W-1:0] w_spd;

  assign w_spd  = COORD_W'(i_speed);
  assign o_wrap = i_move && (r_x < w_spd);
  assign o_x    = r_x;
  assign o_y    = r_y;

  always_ff @(posedge gameClk) begin
    if (reset || i_load) begin
      r_x <= X0;
      r_y <= Y0;
    end else if (i_move) begin
      // Modular step keeps inter-column spacing exact across the respawn.
      if (o_wrap) begin
        r_x <= r_x - w_spd + PER;
        r_y <= i_new_y;
      end else begin
        r_x <= r_x - w_spd;
      end
    end
  end
endmodule

module pipe_field_gen #(
  parameter int          NUM_COLS  = 2,
  parameter int          COORD_W   = 11,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter int          PIPE_W    = 40,
  parameter int          GAP_H     = 50,
  parameter int          PADDING   = 20,
  parameter int          SPACING   = 320,
  parameter int          SPEED_W   = 3,
  parameter int          SCORE_W   = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         IDX_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                        gameClk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        finished,
  input  logic [SPEED_W-1:0]          speed,
  output logic [NUM_COLS*COORD_W-1:0] colX,
  output logic [NUM_COLS*COORD_W-1:0] colY,
  output logic                        passColumn,
  output logic [IDX_W-1:0]            passIdx,
  output logic [SCORE_W-1:0]          passCount,
  output logic                        running
);
  localparam int RESPAWN_X = SCREEN_W + 2*PIPE_W - 1;
  localparam int FIRST_X   = SCREEN_W/2 + 2*PIPE_W - 1;
  localparam int Y_MIN     = GAP_H + PADDING;
  localparam int Y_RANGE   = SCREEN_H - 2*Y_MIN;
  localparam int PERIOD    = RESPAWN_X + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

  state_t              r_state, w_state_nxt;
  logic                w_move, w_load;
  logic [15:0]         r_lfsr, w_lfsr_nxt, w_mod;
  logic [COORD_W-1:0]  w_new_y;
  logic [NUM_COLS-1:0] w_wrap;
  logic                w_any;
  logic [IDX_W-1:0]    w_idx;
  logic                r_pass, r_running;
  logic [IDX_W-1:0]    r_idx;
  logic [SCORE_W-1:0]  r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_move      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_RUN;
      S_RUN:    if (finished) w_state_nxt = S_FROZEN;
                else w_move = 1'b1;
      S_FROZEN: if (start) begin
                  w_state_nxt = S_IDLE;
                  w_load      = 1'b1;
                end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
  assign w_mod      = r_lfsr % 16'(Y_RANGE);
  assign w_new_y    = COORD_W'(32'(Y_MIN) + 32'(w_mod));

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
    pipe_col #(
      .COORD_W(COORD_W), .SPEED_W(SPEED_W),
      .INIT_X(FIRST_X + i*SPACING), .INIT_Y(SCREEN_H/2), .PERIOD(PERIOD)
    ) u_col (
      .gameClk(gameClk), .reset(reset), .i_move(w_move), .i_load(w_load),
      .i_speed(speed), .i_new_y(w_new_y),
      .o_x(colX[i*COORD_W +: COORD_W]), .o_y(colY[i*COORD_W +: COORD_W]),
      .o_wrap(w_wrap[i])
    );
  end

  assign w_any = |w_wrap;

  always_comb begin
    w_idx = '0;
    for (int i = NUM_COLS-1; i >= 0; i--)
      if (w_wrap[i]) w_idx = IDX_W'(i);
  end

  always_ff @(posedge gameClk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_pass    <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_pass    <= w_any;
      r_running <= (w_state_nxt == S_RUN);
      if (w_any) r_idx <= w_idx;
      if (w_load) r_cnt <= '0;
      else if (w_any && (r_cnt != {SCORE_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign passColumn = r_pass;
  assign passIdx    = r_idx;
  assign passCount  = r_cnt;
  assign running    = r_running;
endmodule

// File: tb/tb_pipe_field_gen.sv
// Directed bench for pipe_field_gen; wrap events are checked by a scoreboard monitor.
module tb_pipe_field_gen;
  localparam int NWRAP = 300;

  logic        gameClk = 1'b0;
  logic        reset, start, finished;
  logic [2:0]  speed;
  logic [21:0] colX, colY;
  logic        passColumn;
  logic [0:0]  passIdx;
  logic [3:0]  passCount;
  logic        running;

  pipe_field_gen #(.SCORE_W(4)) dut (
    .gameClk(gameClk), .reset(reset), .start(start), .finished(finished),
    .speed(speed), .colX(colX), .colY(colY), .passColumn(passColumn),
    .passIdx(passIdx), .passCount(passCount), .running(running)
  );

  always #5 gameClk = ~gameClk;

  typedef struct {
    int idx;
    int cnt;
    bit chk_x;
    int x0;
    int x1;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, n_pulse = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference LFSR: Galois, mask B400, advances every clock, seeded on reset.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  logic [15:0] m_lfsr, m_prev;
  always @(posedge gameClk) begin
    m_prev <= m_lfsr;
    m_lfsr <= reset ? 16'hACE1 : lfsr_step(m_lfsr);
  end

  function automatic int x0f(); return int'(colX[10:0]);  endfunction
  function automatic int x1f(); return int'(colX[21:11]); endfunction
  function automatic int yf(input int i); return int'(colY[i*11 +: 11]); endfunction

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge gameClk) begin
    if (passColumn === 1'b1) begin
      n_pulse++;
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        int   y;
        e = q.pop_front();
        y = yf(e.idx);
        chk("passIdx", int'(passIdx), e.idx);
        chk("passCount", int'(passCount), e.cnt);
        chk("wrap_y", y, 70 + int'(m_prev % 16'd340));
        chk("wrap_y_range", int'(y >= 70 && y <= 409), 1);
        if (e.chk_x) begin
          chk("wrap_x0", x0f(), e.x0);
          chk("wrap_x1", x1f(), e.x1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge gameClk);
  endtask

  task automatic push(input int idx, input int cnt, input bit cx, input int x0, input int x1);
    exp_t e;
    e.idx = idx; e.cnt = cnt; e.chk_x = cx; e.x0 = x0; e.x1 = x1;
    q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x0"}, x0f(), 399);
    chk({tag, "_x1"}, x1f(), 719);
    chk({tag, "_y0"}, yf(0), 240);
    chk({tag, "_y1"}, yf(1), 240);
    chk({tag, "_cnt"}, int'(passCount), 0);
    chk({tag, "_run"}, int'(running), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finished = 1'b0; speed = '0;
    tick(2);
    reset = 1'b0;
    tick(10);
    chk_reset_vals("idle");
    chk("idle_pass", int'(passColumn), 0);

    // First wrap at speed 1
    start = 1'b1; speed = 3'd1;
    tick(1);
    start = 1'b0;
    chk("run_after_start", int'(running), 1);
    tick(399);
    chk("pre_wrap_x0", x0f(), 0);
    chk("pre_wrap_x1", x1f(), 320);
    push(0, 1, 1'b1, 719, 319);
    tick(1);
    tick(1);
    chk("pulse_one_cycle", int'(passColumn), 0);
    chk("post_wrap_x0", x0f(), 718);

    // Column 1 wraps next; then speed 3 from x0=1
    push(1, 2, 1'b1, 399, 719);
    tick(717);
    chk("x0_at_1", x0f(), 1);
    chk("x1_at_321", x1f(), 321);
    push(0, 3, 1'b1, 718, 318);
    speed = 3'd3;
    tick(1);
    speed = 3'd0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("spd0_x0", x0f(), 718);
      chk("spd0_x1", x1f(), 318);
      chk("spd0_pass", int'(passColumn), 0);
    end

    // finished beats start in RUN; then start from FROZEN reloads
    finished = 1'b1; start = 1'b1;
    tick(1);
    finished = 1'b0; start = 1'b0; speed = 3'd5;
    chk("frozen_run", int'(running), 0);
    tick(3);
    chk("frozen_x0", x0f(), 718);
    chk("frozen_x1", x1f(), 318);
    chk("frozen_cnt", int'(passCount), 3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk_reset_vals("reload");

    // Reset mid-run
    start = 1'b1; speed = 3'd1;
    tick(1);
    start = 1'b0;
    tick(299);
    chk("midrun_x0", x0f(), 100);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_reset_vals("midreset");

    // Long run at speed 7: alternate columns, score saturates at 15
    for (int i = 1; i <= NWRAP; i++)
      push((i - 1) % 2, (i < 15) ? i : 15, 1'b0, 0, 0);
    n_pulse = 0;
    start = 1'b1; speed = 3'd7;
    tick(1);
    start = 1'b0;
    for (int c = 0; c < 40000 && n_pulse < NWRAP; c++) tick(1);
    chk("wrap_total", n_pulse, NWRAP);
    chk("sat_cnt", int'(passCount), 15);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
